// File: rtl/in_buffer.sv
// rtl/in_buffer.sv - single-bank AXI-Stream frame buffer: receive a whole frame, then replay it gap-free.
// Optional macro IN_BUFFER_STRB_MASK_EN zeroes byte lanes whose tstrb bit is low before storing.
module in_buffer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 800,
    parameter int ADDR_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tstrb,
    input  logic                  s_axis_tlast,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [15:0]           frame_cnt,
    output logic                  err_short,
    output logic                  err_long
);
    typedef enum logic [1:0] {ST_RECV, ST_DISCARD, ST_DRAIN} state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, len_q;
    logic                rd_busy_q, rd_vld_q, rd_last_q;
    logic [DATA_W-1:0]   rd_data_q, out_data_q;
    logic                out_valid_q, out_last_q;
    logic [15:0]         frame_cnt_q;
    logic                err_short_q, err_long_q;

    logic                accept, wr_en, rd_issue, rd_at_end, drain_done;
    logic [DATA_W-1:0]   wr_data;

    logic [DATA_W-1:0]   mem [FRAME_LEN];

`ifdef IN_BUFFER_STRB_MASK_EN
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < DATA_W/8; i++) begin
            wr_data[8*i +: 8] = s_axis_tstrb[i] ? s_axis_tdata[8*i +: 8] : 8'h00;
        end
    end
`else
    logic unused_strb;
    assign unused_strb = &{1'b0, s_axis_tstrb};
    assign wr_data     = s_axis_tdata;
`endif

    assign rd_at_end = (rd_ptr_q == len_q - ADDR_W'(1));

    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        accept        = 1'b0;
        wr_en         = 1'b0;
        rd_issue      = 1'b0;
        drain_done    = 1'b0;
        case (state_q)
            ST_RECV: begin
                s_axis_tready = ~rst;
                accept        = s_axis_tvalid & ~rst;
                wr_en         = accept;
                if (accept && s_axis_tlast) begin
                    state_d = ST_DRAIN;
                end else if (accept && wr_ptr_q == LAST_IDX) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                s_axis_tready = ~rst;
                accept        = s_axis_tvalid & ~rst;
                if (accept && s_axis_tlast) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                rd_issue   = rd_busy_q;
                drain_done = out_last_q;
                if (out_last_q) begin
                    state_d = ST_RECV;
                end
            end
            default: state_d = ST_RECV;
        endcase
    end

    // Storage and its registered read port carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
        if (rd_issue) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RECV;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            rd_busy_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                if (s_axis_tlast || wr_ptr_q == LAST_IDX) begin
                    len_q <= wr_ptr_q + ADDR_W'(1);
                end else begin
                    wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
                end
                if (s_axis_tlast && wr_ptr_q != LAST_IDX) begin
                    err_short_q <= 1'b1;
                end
                if (!s_axis_tlast && wr_ptr_q == LAST_IDX) begin
                    err_long_q <= 1'b1;
                end
            end
            if (accept && s_axis_tlast) begin
                rd_busy_q <= 1'b1;
                rd_ptr_q  <= '0;
            end
            // Two-stage replay pipe: RAM read register, then output register.
            rd_vld_q  <= rd_issue;
            rd_last_q <= rd_issue & rd_at_end;
            if (rd_issue) begin
                if (rd_at_end) begin
                    rd_busy_q <= 1'b0;
                end else begin
                    rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                end
            end
            out_valid_q <= rd_vld_q;
            out_last_q  <= rd_last_q;
            out_data_q  <= rd_vld_q ? rd_data_q : '0;
            if (drain_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_cnt = frame_cnt_q;
    assign err_short = err_short_q;
    assign err_long  = err_long_q;
endmodule

// File: tb/tb_in_buffer.sv
// tb/tb_in_buffer.sv - directed self-checking bench for in_buffer.
module tb_in_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tstrb = 4'hF;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic [15:0] frame_cnt;
    logic        err_short;
    logic        err_long;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] out_q[$];
    logic        lflag_q[$];
    int          lastcnt = 0;
    int          lowcnt  = 0;
    int          gapcnt  = 0;
    logic        prev_v  = 1'b0;
    logic        prev_l  = 1'b0;

    in_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tlast  (s_axis_tlast),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .frame_cnt     (frame_cnt),
        .err_short     (err_short),
        .err_long      (err_long)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                out_q.push_back(out_data);
                lflag_q.push_back(out_last);
            end
            if (out_last) lastcnt++;
            if (!s_axis_tready) lowcnt++;
            if (prev_v && !prev_l && !out_valid) gapcnt++;
            prev_v = out_valid;
            prev_l = out_last;
        end else begin
            prev_v = 1'b0;
            prev_l = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        out_q.delete();
        lflag_q.delete();
        lastcnt = 0;
        lowcnt  = 0;
        gapcnt  = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
    endtask

    task automatic send_frame(input int nbeats, input int last_idx, input bit gaps,
                              input logic [31:0] base);
        int i = 0;
        int c = 0;
        while (i < nbeats && c < 5000) begin
            @(posedge clk); #1;
            s_axis_tvalid = gaps ? (c % 3 != 2) : 1'b1;
            s_axis_tdata  = base + 32'(i);
            s_axis_tlast  = (i == last_idx);
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) i++;
            c++;
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (i < nbeats) chk("send_timeout", i, nbeats);
    endtask

    task automatic wait_last(input string tag);
        int c = 0;
        while (lastcnt == 0 && c < 3000) begin
            @(negedge clk); #1;
            c++;
        end
        if (lastcnt == 0) chk(tag, 0, 1);
    endtask

    task automatic check_frame(input string tag, input int n, input logic [31:0] base);
        int bad = 0;
        int lasts = 0;
        chk({tag, "_count"}, out_q.size(), n);
        foreach (out_q[k]) begin
            if (out_q[k] !== base + 32'(k)) bad++;
            if (lflag_q[k]) lasts++;
        end
        chk({tag, "_data_errs"}, bad, 0);
        chk({tag, "_last_cnt"}, lasts, 1);
        if (out_q.size() == n) chk({tag, "_last_pos"}, lflag_q[n-1], 1);
    endtask

    initial begin
        logic [31:0] exp6;
        // reset state
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 0);
        do_reset();
        @(negedge clk);
        chk("rst_tready_after", s_axis_tready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_errs", {err_short, err_long}, 0);

        // 1) full frame, continuous
        send_frame(800, 799, 1'b0, 32'd0);
        wait_last("t1_no_last");
        check_frame("t1", 800, 32'd0);
        chk("t1_gaps", gapcnt, 0);
        @(negedge clk); #1;
        chk("t1_valid_after", out_valid, 0);
        chk("t1_tready_after", s_axis_tready, 1);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_errs", {err_short, err_long}, 0);

        // 2) short frame: tready low N+2 cycles
        do_reset();
        send_frame(5, 4, 1'b0, 32'hA0);
        wait_last("t2_no_last");
        @(negedge clk); #1;
        check_frame("t2", 5, 32'hA0);
        chk("t2_tready_low", lowcnt, 7);
        chk("t2_err_short", err_short, 1);
        chk("t2_err_long", err_long, 0);
        chk("t2_frame_cnt", frame_cnt, 1);

        // 3) long frame: excess beats dropped
        do_reset();
        send_frame(803, 802, 1'b0, 32'd0);
        wait_last("t3_no_last");
        check_frame("t3", 800, 32'd0);
        chk("t3_err_long", err_long, 1);
        chk("t3_err_short", err_short, 0);

        // 4) tvalid gaps on input, replay still gap-free
        do_reset();
        send_frame(800, 799, 1'b1, 32'd0);
        wait_last("t4_no_last");
        check_frame("t4", 800, 32'd0);
        chk("t4_gaps", gapcnt, 0);

        // 5) reset during replay of word 400
        do_reset();
        send_frame(800, 799, 1'b0, 32'd0);
        begin
            int c = 0;
            while (out_q.size() < 401 && c < 3000) begin
                @(negedge clk); #1;
                c++;
            end
        end
        chk("t5_word400", out_q[out_q.size()-1], 32'd400);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        chk("t5_valid_after_rst", out_valid, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("t5_no_last", lastcnt, 0);
        chk("t5_frame_cnt", frame_cnt, 0);
        clear_mon();
        send_frame(800, 799, 1'b0, 32'h1000);
        wait_last("t5b_no_last");
        check_frame("t5b", 800, 32'h1000);
        @(negedge clk); #1;
        chk("t5b_frame_cnt", frame_cnt, 1);

        // 6) strobe masking
        do_reset();
        s_axis_tstrb = 4'b0101;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hAABBCCDD;
        s_axis_tlast  = 1'b1;
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tstrb  = 4'hF;
        wait_last("t6_no_last");
`ifdef IN_BUFFER_STRB_MASK_EN
        exp6 = 32'h00BB00DD;
`else
        exp6 = 32'hAABBCCDD;
`endif
        chk("t6_count", out_q.size(), 1);
        if (out_q.size() > 0) chk("t6_data", out_q[0], exp6);
        chk("t6_err_short", err_short, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
